// File: rtl/matrix_mem_pkg.sv
`default_nettype none
// ============================================================================
// matrix_mem_pkg : shared widths, opcodes, port ids and FSM states
// Revision: 1.0
// ============================================================================
package matrix_mem_pkg;

  localparam int ADDR_WIDTH = 15;
  localparam int DATA_WIDTH = 32;

  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  localparam logic PORT_LD   = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/word_ram.sv
`default_nettype none
// ============================================================================
// word_ram : single-port synchronous RAM, WORDS x 32, registered read port
// Revision: 1.0
// ============================================================================
module word_ram
  import matrix_mem_pkg::*;
#(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/matrix_memory.sv
`default_nettype none
// ============================================================================
// matrix_memory : two-port (loader/host) scratchpad, round-robin onto one RAM
// Revision: 1.0
// ============================================================================
module matrix_memory
  import matrix_mem_pkg::*;
#(
  parameter int unsigned WORDS   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ld_enable,
  input  logic                  ld_read_write,
  input  logic [ADDR_WIDTH-1:0] ld_address,
  input  logic [DATA_WIDTH-1:0] ld_word_in,
  output logic [DATA_WIDTH-1:0] ld_word_out,
  output logic                  ld_done,
  input  logic                  host_enable,
  input  logic                  host_read_write,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic [DATA_WIDTH-1:0] host_word_in,
  output logic [DATA_WIDTH-1:0] host_word_out,
  output logic                  host_done
);

  localparam int unsigned      RAM_AW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned      CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < WORDS;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  rd_q, rd_d;
  logic                  inr_q, inr_d;
  logic                  ld_pend_q, ld_pend_d;
  logic                  host_pend_q, host_pend_d;
  mem_req_t              ld_req_q, ld_req_d;
  mem_req_t              host_req_q, host_req_d;
  logic                  ld_done_q, ld_done_d;
  logic                  host_done_q, host_done_d;
  logic [DATA_WIDTH-1:0] ld_word_q, ld_word_d;
  logic [DATA_WIDTH-1:0] host_word_q, host_word_d;

  logic                  sel;
  mem_req_t              sel_req;
  logic                  ram_en;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  word_ram #(
    .WORDS (WORDS),
    .AW    (RAM_AW)
  ) u_ram (
    .clk_i   (clock),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (sel_req.addr[RAM_AW-1:0]),
    .wdata_i (sel_req.data),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gnt_q       <= PORT_LD;
      last_q      <= PORT_HOST;
      rd_q        <= 1'b0;
      inr_q       <= 1'b0;
      ld_pend_q   <= 1'b0;
      host_pend_q <= 1'b0;
      ld_req_q    <= '0;
      host_req_q  <= '0;
      ld_done_q   <= 1'b0;
      host_done_q <= 1'b0;
      ld_word_q   <= '0;
      host_word_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      rd_q        <= rd_d;
      inr_q       <= inr_d;
      ld_pend_q   <= ld_pend_d;
      host_pend_q <= host_pend_d;
      ld_req_q    <= ld_req_d;
      host_req_q  <= host_req_d;
      ld_done_q   <= ld_done_d;
      host_done_q <= host_done_d;
      ld_word_q   <= ld_word_d;
      host_word_q <= host_word_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    rd_d        = rd_q;
    inr_d       = inr_q;
    ld_pend_d   = ld_pend_q;
    host_pend_d = host_pend_q;
    ld_req_d    = ld_req_q;
    host_req_d  = host_req_q;
    ld_done_d   = 1'b0;
    host_done_d = 1'b0;
    ld_word_d   = ld_word_q;
    host_word_d = host_word_q;
    sel         = PORT_LD;
    sel_req     = ld_req_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ld_pend_q || host_pend_q) begin
          if (ld_pend_q && host_pend_q) begin
            sel = (last_q == PORT_LD) ? PORT_HOST : PORT_LD;
          end else begin
            sel = ld_pend_q ? PORT_LD : PORT_HOST;
          end
          sel_req = (sel == PORT_LD) ? ld_req_q : host_req_q;
          // Out-of-range requests never touch the RAM, so they cannot alias.
          ram_en  = reset && in_range(sel_req.addr);
          ram_we  = (sel_req.rw == MEM_WRITE);
          gnt_d   = sel;
          last_d  = sel;
          rd_d    = (sel_req.rw == MEM_READ);
          inr_d   = in_range(sel_req.addr);
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
          if (sel == PORT_LD) begin
            ld_pend_d = 1'b0;
          end else begin
            host_pend_d = 1'b0;
          end
        end
      end
      S_ACCESS: begin
        // Wait state spans LATENCY cycles so done rises LATENCY edges after grant.
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (gnt_q == PORT_LD) begin
            ld_done_d = 1'b1;
            if (rd_q) ld_word_d = inr_q ? ram_rdata : '0;
          end else begin
            host_done_d = 1'b1;
            if (rd_q) host_word_d = inr_q ? ram_rdata : '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (ld_enable && !ld_pend_q) begin
      ld_pend_d = 1'b1;
      ld_req_d  = {ld_read_write, ld_address, ld_word_in};
    end
    if (host_enable && !host_pend_q) begin
      host_pend_d = 1'b1;
      host_req_d  = {host_read_write, host_address, host_word_in};
    end
  end

  assign ld_done       = ld_done_q;
  assign host_done     = host_done_q;
  assign ld_word_out   = ld_word_q;
  assign host_word_out = host_word_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_memory.sv
`default_nettype none
// ============================================================================
// tb_matrix_memory : scoreboard bench for matrix_memory (WORDS=4096, LATENCY=2)
// Revision: 1.0
// ============================================================================
module tb_matrix_memory;

  localparam bit P_LD   = 1'b0;
  localparam bit P_HOST = 1'b1;
  localparam logic RD   = 1'b1;
  localparam logic WR   = 1'b0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ld_enable = 1'b0, ld_read_write = 1'b0;
  logic [14:0] ld_address = '0;
  logic [31:0] ld_word_in = '0;
  logic [31:0] ld_word_out;
  logic        ld_done;
  logic        host_enable = 1'b0, host_read_write = 1'b0;
  logic [14:0] host_address = '0;
  logic [31:0] host_word_in = '0;
  logic [31:0] host_word_out;
  logic        host_done;

  matrix_memory #(.WORDS(4096), .LATENCY(2)) dut (
    .clock           (clock),
    .reset           (reset),
    .ld_enable       (ld_enable),
    .ld_read_write   (ld_read_write),
    .ld_address      (ld_address),
    .ld_word_in      (ld_word_in),
    .ld_word_out     (ld_word_out),
    .ld_done         (ld_done),
    .host_enable     (host_enable),
    .host_read_write (host_read_write),
    .host_address    (host_address),
    .host_word_in    (host_word_in),
    .host_word_out   (host_word_out),
    .host_done       (host_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_ld[$];
  exp_t        exp_host[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] ld_last = '0;
  logic [31:0] host_last = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t it;
    if (ld_done) begin
      if (exp_ld.size() == 0) begin
        check("ld_unexpected_done", 32'd1, 32'd0);
      end else begin
        it = exp_ld.pop_front();
        check("ld_done_cycle", 32'(cyc), 32'(it.cyc));
        check("ld_word_out", ld_word_out, it.word);
      end
    end
    if (host_done) begin
      if (exp_host.size() == 0) begin
        check("host_unexpected_done", 32'd1, 32'd0);
      end else begin
        it = exp_host.pop_front();
        check("host_done_cycle", 32'(cyc), 32'(it.cyc));
        check("host_word_out", host_word_out, it.word);
      end
    end
  end

  // Drives one request for the coming edge; dly = edges from sampling to done.
  task automatic drive(input bit port, input logic rw, input logic [14:0] a,
                       input logic [31:0] d, input int dly, input logic [31:0] rd_exp,
                       input bit push);
    exp_t it;
    it.cyc = cyc + 1 + dly;
    if (rw == RD) it.word = rd_exp;
    else          it.word = (port == P_LD) ? ld_last : host_last;
    if (port == P_LD) begin
      ld_enable = 1'b1; ld_read_write = rw; ld_address = a; ld_word_in = d;
      if (push) begin
        if (rw == RD) ld_last = rd_exp;
        exp_ld.push_back(it);
      end
    end else begin
      host_enable = 1'b1; host_read_write = rw; host_address = a; host_word_in = d;
      if (push) begin
        if (rw == RD) host_last = rd_exp;
        exp_host.push_back(it);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    ld_enable   = 1'b0;
    host_enable = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_ld.size() != 0 || exp_host.size() != 0) && n < budget) begin
      @(negedge clock);
      #1;
      n++;
    end
    if (exp_ld.size() != 0 || exp_host.size() != 0) begin
      check("drain_timeout", 32'(exp_ld.size() + exp_host.size()), 32'd0);
      exp_ld.delete();
      exp_host.delete();
    end
  endtask

  task automatic single(input bit port, input logic rw, input logic [14:0] a,
                        input logic [31:0] d, input logic [31:0] rd_exp);
    drive(port, rw, a, d, 3, rd_exp, 1'b1);
    tick();
    wait_drain(20);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_ld_done", {31'd0, ld_done}, 32'd0);
    check("rst_host_done", {31'd0, host_done}, 32'd0);
    check("rst_ld_word", ld_word_out, 32'd0);
    check("rst_host_word", host_word_out, 32'd0);
    #1 reset = 1'b1;
    @(negedge clock);
    #1;

    // Host preload, then loader fetch one request per done
    for (int i = 0; i < 4; i++) single(P_HOST, WR, 15'h0100 + 15'(i), 32'(i + 1), '0);
    for (int i = 0; i < 4; i++) single(P_LD, RD, 15'h0100 + 15'(i), '0, 32'(i + 1));

    // Contention: last grant is host, so loader wins the first pair
    single(P_HOST, WR, 15'h0000, 32'h1111_1111, '0);
    drive(P_LD, RD, 15'h0000, '0, 3, 32'h1111_1111, 1'b1);
    drive(P_HOST, WR, 15'h0000, 32'hDEAD_BEEF, 7, '0, 1'b1);
    tick();
    wait_drain(30);
    single(P_LD, RD, 15'h0000, '0, 32'hDEAD_BEEF);
    drive(P_LD, RD, 15'h0100, '0, 7, 32'd1, 1'b1);
    drive(P_HOST, RD, 15'h0000, '0, 3, 32'hDEAD_BEEF, 1'b1);
    tick();
    wait_drain(30);

    // Out-of-range write must not alias onto 0x0FFF
    single(P_LD, WR, 15'h0FFF, 32'hCAFE_F00D, '0);
    single(P_HOST, WR, 15'h7FFF, 32'h1234_5678, '0);
    single(P_LD, RD, 15'h0FFF, '0, 32'hCAFE_F00D);
    single(P_LD, RD, 15'h7FFF, '0, 32'h0);

    // Dropped request: second loader enable while the first is still pending
    drive(P_HOST, RD, 15'h0103, '0, 3, 32'd4, 1'b1);
    tick();
    drive(P_LD, RD, 15'h0101, '0, 6, 32'd2, 1'b1);
    tick();
    drive(P_LD, RD, 15'h0102, '0, 0, '0, 1'b0);
    tick();
    wait_drain(30);

    // Write then read sampled on the write's done edge
    drive(P_LD, WR, 15'h0010, 32'hA5A5_A5A5, 3, '0, 1'b1);
    tick();
    repeat (2) @(posedge clock);
    #1;
    drive(P_LD, RD, 15'h0010, '0, 4, 32'hA5A5_A5A5, 1'b1);
    tick();
    wait_drain(30);

    // Reset during a loader write: no done, write stays committed
    drive(P_LD, WR, 15'h0020, 32'h7777_7777, 0, '0, 1'b0);
    tick();
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("midrst_ld_word", ld_word_out, 32'd0);
    check("midrst_host_word", host_word_out, 32'd0);
    check("midrst_ld_done", {31'd0, ld_done}, 32'd0);
    check("midrst_host_done", {31'd0, host_done}, 32'd0);
    reset = 1'b1;
    ld_last   = '0;
    host_last = '0;
    repeat (3) @(negedge clock);
    #1;

    // Priority back to loader after reset
    drive(P_LD, RD, 15'h0020, '0, 3, 32'h7777_7777, 1'b1);
    drive(P_HOST, RD, 15'h0010, '0, 7, 32'hA5A5_A5A5, 1'b1);
    tick();
    wait_drain(30);

    repeat (6) @(negedge clock);
    check("ld_pending_left", 32'(exp_ld.size()), 32'd0);
    check("host_pending_left", 32'(exp_host.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
